// File: rtl/touch_key_ctrl.sv
// Multi-channel touch-key front end and LED controller.
// Each channel: 2-FF synchroniser, stability-counter debounce, press/long-press
// event pulses and a per-channel runtime LED mode (toggle/momentary/long/off).

module touch_key_ch #(
  parameter int   DEB_CNT   = 50000,
  parameter int   LONG_CNT  = 50000000,
  parameter logic TOUCH_ACT = 1'b0,
  parameter logic LED_INIT  = 1'b1
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       touch_key,
  input  logic [1:0] mode,
  output logic       led,
  output logic       press_pulse,
  output logic       long_pulse
);

  localparam int   DW   = $clog2(DEB_CNT) + 1;
  localparam int   HW   = $clog2(LONG_CNT + 1);
  localparam logic IDLE = ~TOUCH_ACT;

  localparam logic [1:0] MODE_TOG  = 2'b00;
  localparam logic [1:0] MODE_MOM  = 2'b01;
  localparam logic [1:0] MODE_LONG = 2'b10;
  localparam logic [1:0] MODE_DIS  = 2'b11;

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CNT - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CNT);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CNT - 1);

  logic          s1, s2;
  logic          deb_state, deb_prev;
  logic [DW-1:0] deb_cnt;
  logic [HW-1:0] hold_cnt;
  logic          press_ev, release_ev, held, long_ev;

  // Two-flop synchroniser; resets to idle so reset release never looks like an edge
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1 <= IDLE;
      s2 <= IDLE;
    end else begin
      s1 <= touch_key;
      s2 <= s1;
    end
  end

  // Debounce: accept a new level only after DEB_CNT consecutive differing samples
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      deb_state <= IDLE;
      deb_cnt   <= '0;
    end else if (s2 == deb_state) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      deb_state <= s2;
      deb_cnt   <= '0;
    end else begin
      deb_cnt <= deb_cnt + DW'(1);
    end
  end

  // Delayed debounced level for edge detection
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) deb_prev <= IDLE;
    else            deb_prev <= deb_state;
  end

  // Event decode; the press edge itself is hold count 0, so long fires LONG_CNT
  // edges after press_pulse. Release sees the idle level, so it can never
  // coincide with the long event.
  always_comb begin
    press_ev   = (deb_state == TOUCH_ACT) && (deb_prev != TOUCH_ACT);
    release_ev = (deb_state != TOUCH_ACT) && (deb_prev == TOUCH_ACT);
    held       = (deb_state == TOUCH_ACT) && (deb_prev == TOUCH_ACT);
    long_ev    = held && (hold_cnt == HOLD_LAST);
  end

  // Hold length counter, saturating so the long event fires once per press
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                            hold_cnt <= '0;
    else if (deb_state != TOUCH_ACT)           hold_cnt <= '0;
    else if (held && (hold_cnt < HOLD_MAX))    hold_cnt <= hold_cnt + HW'(1);
  end

  // Registered event pulses
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      press_pulse <= 1'b0;
      long_pulse  <= 1'b0;
    end else begin
      press_pulse <= press_ev;
      long_pulse  <= long_ev;
    end
  end

  // LED update; mode is used live so a mode write on an event edge takes effect there
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      led <= LED_INIT;
    end else begin
      unique case (mode)
        MODE_TOG:  if (press_ev) led <= ~led;
        MODE_MOM:  led <= (deb_state == TOUCH_ACT) ? ~LED_INIT : LED_INIT;
        MODE_LONG: begin
          if (long_ev)                                   led <= LED_INIT;
          else if (release_ev && (hold_cnt < HOLD_MAX))  led <= ~led;
        end
        MODE_DIS:  led <= LED_INIT;
        default:   led <= LED_INIT;
      endcase
    end
  end

endmodule

module touch_key_ctrl #(
  parameter int   CH_NUM    = 4,
  parameter int   DEB_CNT   = 50000,
  parameter int   LONG_CNT  = 50000000,
  parameter logic TOUCH_ACT = 1'b0,
  parameter logic LED_INIT  = 1'b1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [CH_NUM-1:0]     touch_key,
  input  logic [2*CH_NUM-1:0]   mode,
  output logic [CH_NUM-1:0]     led,
  output logic [CH_NUM-1:0]     press_pulse,
  output logic [CH_NUM-1:0]     long_pulse
);

  // Fully independent channels, no shared state
  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    touch_key_ch #(
      .DEB_CNT   (DEB_CNT),
      .LONG_CNT  (LONG_CNT),
      .TOUCH_ACT (TOUCH_ACT),
      .LED_INIT  (LED_INIT)
    ) u_ch (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .touch_key   (touch_key[i]),
      .mode        (mode[2*i +: 2]),
      .led         (led[i]),
      .press_pulse (press_pulse[i]),
      .long_pulse  (long_pulse[i])
    );
  end

endmodule

// File: tb/tb_touch_key_ctrl.sv
// Self-checking bench for touch_key_ctrl: directed scenarios plus random soak,
// every cycle compared against a behavioural model of the key/LED rules.

module tb_touch_key_ctrl;

  localparam int   CH   = 2;
  localparam int   DEB  = 4;
  localparam int   LONG = 16;
  localparam logic ACT  = 1'b0;
  localparam logic LI   = 1'b1;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic [CH-1:0]     touch_key = '1;
  logic [2*CH-1:0]   mode = '0;
  logic [CH-1:0]     led, press_pulse, long_pulse;

  always #5 sys_clk = ~sys_clk;

  touch_key_ctrl #(
    .CH_NUM(CH), .DEB_CNT(DEB), .LONG_CNT(LONG), .TOUCH_ACT(ACT), .LED_INIT(LI)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .touch_key(touch_key), .mode(mode),
    .led(led), .press_pulse(press_pulse), .long_pulse(long_pulse)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model: recent raw samples, debounced level history, press bookkeeping
  logic          m_samp [CH][DEB+1];
  logic          m_deb [CH];
  logic          m_deb_d [CH];
  int            m_p [CH];
  bit            m_pr [CH];
  logic [CH-1:0] m_led, m_press, m_long;

  function automatic void model_reset();
    for (int ch = 0; ch < CH; ch++) begin
      for (int k = 0; k <= DEB; k++) m_samp[ch][k] = ~ACT;
      m_deb[ch] = ~ACT; m_deb_d[ch] = ~ACT; m_p[ch] = 0; m_pr[ch] = 0;
    end
    m_led = {CH{LI}}; m_press = '0; m_long = '0;
  endfunction

  function automatic void model_edge();
    for (int ch = 0; ch < CH; ch++) begin
      logic old, older, nd;
      bit prs, rel, lng, short_rel, same;
      logic [1:0] md;
      old = m_deb[ch]; older = m_deb_d[ch]; md = mode[2*ch +: 2];
      prs = (old == ACT) && (older != ACT);
      rel = (old != ACT) && (older == ACT);
      short_rel = 0;
      if (prs) begin m_p[ch] = cyc; m_pr[ch] = 1; end
      if (rel) begin short_rel = ((cyc - m_p[ch]) <= LONG); m_pr[ch] = 0; end
      lng = m_pr[ch] && ((cyc - m_p[ch]) == LONG);
      case (md)
        2'b00: if (prs) m_led[ch] = ~m_led[ch];
        2'b01: m_led[ch] = m_pr[ch] ? ~LI : LI;
        2'b10: begin
          if (lng) m_led[ch] = LI;
          else if (rel && short_rel) m_led[ch] = ~m_led[ch];
        end
        default: m_led[ch] = LI;
      endcase
      m_press[ch] = prs; m_long[ch] = lng;
      // level accepted once the DEB most recent synchronised samples agree on it
      same = 1;
      for (int k = 1; k <= DEB; k++) if (m_samp[ch][k] != m_samp[ch][1]) same = 0;
      nd = (same && (m_samp[ch][1] != old)) ? m_samp[ch][1] : old;
      m_deb_d[ch] = old; m_deb[ch] = nd;
      for (int k = DEB; k >= 1; k--) m_samp[ch][k] = m_samp[ch][k-1];
      m_samp[ch][0] = touch_key[ch];
    end
  endfunction

  // Advance one clock edge, update the model, land 1 time unit after the edge
  task automatic tick();
    @(posedge sys_clk);
    cyc++;
    if (!sys_rst_n) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({led, press_pulse, long_pulse} !== {2'b11, 2'b00, 2'b00}) begin
        failures++;
        $display("FAIL reset_held cyc=%0d got=%b exp=%b", cyc, {led, press_pulse, long_pulse}, 6'b110000);
      end
    end
    sys_rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++;
      if ({led, press_pulse, long_pulse} !== {m_led, m_press, m_long}) begin
        failures++;
        $display("FAIL idle cyc=%0d got=%b exp=%b", cyc, {led, press_pulse, long_pulse}, {m_led, m_press, m_long});
      end
    end
    checks++;
    if ({led, press_pulse, long_pulse} !== 6'b110000) begin
      failures++;
      $display("FAIL idle_end got=%b exp=%b", {led, press_pulse, long_pulse}, 6'b110000);
    end
  endtask

  task automatic test_toggle();
    mode = 4'b0000;
    for (int ph = 0; ph < 4; ph++) begin
      touch_key[0] = ph[0];   // 0: press, 1: release
      for (int i = 0; i < 10; i++) begin
        tick();
        checks++;
        if ({led, press_pulse, long_pulse} !== {m_led, m_press, m_long}) begin
          failures++;
          $display("FAIL toggle cyc=%0d got=%b exp=%b", cyc, {led, press_pulse, long_pulse}, {m_led, m_press, m_long});
        end
        if (ph == 0) begin
          checks++;
          if (press_pulse[0] !== 1'(i == 6) || led[0] !== 1'(i < 6)) begin
            failures++;
            $display("FAIL toggle_edge i=%0d got pp=%b led=%b exp pp=%b led=%b", i, press_pulse[0], led[0], 1'(i == 6), 1'(i < 6));
          end
        end
      end
    end
    checks++;
    if (led !== 2'b11) begin
      failures++;
      $display("FAIL toggle_restore got=%b exp=11", led);
    end
  endtask

  task automatic test_glitch();
    int np;
    logic l0;
    np = 0; l0 = led[0];
    touch_key[0] = 1'b0;
    for (int i = 0; i < 13; i++) begin
      tick();
      checks++;
      if ({led, press_pulse, long_pulse} !== {m_led, m_press, m_long}) begin
        failures++;
        $display("FAIL glitch cyc=%0d got=%b exp=%b", cyc, {led, press_pulse, long_pulse}, {m_led, m_press, m_long});
      end
      np += press_pulse[0];
      if (i == 2) touch_key[0] = 1'b1;
    end
    checks++;
    if (np != 0 || led[0] !== l0) begin
      failures++;
      $display("FAIL glitch_short got presses=%0d led=%b exp presses=0 led=%b", np, led[0], l0);
    end
    np = 0;
    touch_key[0] = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      checks++;
      if ({led, press_pulse, long_pulse} !== {m_led, m_press, m_long}) begin
        failures++;
        $display("FAIL glitch4 cyc=%0d got=%b exp=%b", cyc, {led, press_pulse, long_pulse}, {m_led, m_press, m_long});
      end
      np += press_pulse[0];
      if (i == 3) touch_key[0] = 1'b1;
    end
    checks++;
    if (np != 1) begin
      failures++;
      $display("FAIL glitch_min got presses=%0d exp presses=1", np);
    end
  endtask

  task automatic test_momentary();
    mode = 4'b0100;
    tick(); tick();
    touch_key[1] = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      checks++;
      if ({led, press_pulse, long_pulse} !== {m_led, m_press, m_long} || (i >= 6 && led[1] !== 1'b0)) begin
        failures++;
        $display("FAIL momentary_on cyc=%0d got=%b exp=%b", cyc, {led, press_pulse, long_pulse}, {m_led, m_press, m_long});
      end
    end
    touch_key[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({led, press_pulse, long_pulse} !== {m_led, m_press, m_long} || led[1] !== 1'(i >= 6)) begin
        failures++;
        $display("FAIL momentary_off i=%0d got=%b exp=%b led1_exp=%b", i, {led, press_pulse, long_pulse}, {m_led, m_press, m_long}, 1'(i >= 6));
      end
    end
  endtask

  task automatic test_long();
    logic l0;
    int pidx, lidx, nl;
    mode = 4'b0010;
    tick();
    l0 = led[0];
    touch_key[0] = 1'b0;
    for (int i = 0; i < 22; i++) begin
      tick();
      checks++;
      if ({led, press_pulse, long_pulse} !== {m_led, m_press, m_long}) begin
        failures++;
        $display("FAIL long_short cyc=%0d got=%b exp=%b", cyc, {led, press_pulse, long_pulse}, {m_led, m_press, m_long});
      end
      if (i == 11) touch_key[0] = 1'b1;
    end
    checks++;
    if (led[0] !== ~l0) begin
      failures++;
      $display("FAIL long_short_toggle got=%b exp=%b", led[0], ~l0);
    end
    pidx = -1; lidx = -1; nl = 0;
    touch_key[0] = 1'b0;
    for (int i = 0; i < 44; i++) begin
      tick();
      checks++;
      if ({led, press_pulse, long_pulse} !== {m_led, m_press, m_long}) begin
        failures++;
        $display("FAIL long_hold cyc=%0d got=%b exp=%b", cyc, {led, press_pulse, long_pulse}, {m_led, m_press, m_long});
      end
      if (press_pulse[0]) pidx = i;
      if (long_pulse[0]) begin lidx = i; nl++; end
      if (i == 29) touch_key[0] = 1'b1;
    end
    checks++;
    if (nl != 1 || (lidx - pidx) != LONG || led[0] !== 1'b1) begin
      failures++;
      $display("FAIL long_pulse got n=%0d dist=%0d led=%b exp n=1 dist=%0d led=1", nl, lidx - pidx, led[0], LONG);
    end
  endtask

  task automatic test_reset_mid();
    int np, nl, pidx;
    mode = 4'b0010;
    touch_key[0] = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      checks++;
      if ({led, press_pulse, long_pulse} !== {m_led, m_press, m_long}) begin
        failures++;
        $display("FAIL rst_pre cyc=%0d got=%b exp=%b", cyc, {led, press_pulse, long_pulse}, {m_led, m_press, m_long});
      end
    end
    sys_rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({led, press_pulse, long_pulse} !== 6'b110000) begin
      failures++;
      $display("FAIL rst_async got=%b exp=%b", {led, press_pulse, long_pulse}, 6'b110000);
    end
    tick(); tick();
    sys_rst_n = 1'b1;
    pidx = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if ({led, press_pulse, long_pulse} !== {m_led, m_press, m_long}) begin
        failures++;
        $display("FAIL rst_release cyc=%0d got=%b exp=%b", cyc, {led, press_pulse, long_pulse}, {m_led, m_press, m_long});
      end
      if (press_pulse[0]) pidx = i;
    end
    checks++;
    if (pidx != DEB + 2) begin
      failures++;
      $display("FAIL rst_press_at got=%0d exp=%0d", pidx, DEB + 2);
    end
    // disabled mode: LED forced off, pulses still produced
    mode = 4'b1111;
    touch_key = 2'b11;
    np = 0; nl = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++;
      if ({led, press_pulse, long_pulse} !== {m_led, m_press, m_long} || led !== 2'b11) begin
        failures++;
        $display("FAIL disabled cyc=%0d got=%b exp=%b", cyc, {led, press_pulse, long_pulse}, {m_led, m_press, m_long});
      end
      np += press_pulse[1]; nl += long_pulse[1];
      if (i == 9) touch_key[1] = 1'b0;
      if (i == 39) touch_key[1] = 1'b1;
    end
    checks++;
    if (np != 1 || nl != 1) begin
      failures++;
      $display("FAIL disabled_pulses got press=%0d long=%0d exp press=1 long=1", np, nl);
    end
  endtask

  task automatic test_random();
    int run [CH];
    for (int ch = 0; ch < CH; ch++) run[ch] = 1;
    for (int i = 0; i < 900; i++) begin
      for (int ch = 0; ch < CH; ch++) begin
        run[ch]--;
        if (run[ch] <= 0) begin
          touch_key[ch] = ~touch_key[ch];
          run[ch] = $urandom_range(1, 26);
        end
      end
      if (($urandom % 25) == 0) mode = 4'($urandom);
      tick();
      checks++;
      if ({led, press_pulse, long_pulse} !== {m_led, m_press, m_long}) begin
        failures++;
        $display("FAIL random cyc=%0d got=%b exp=%b", cyc, {led, press_pulse, long_pulse}, {m_led, m_press, m_long});
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_toggle();
    test_glitch();
    test_momentary();
    test_long();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/touch_key_ctrl.md
Name: touch_key_ctrl

Overview:
Multi-channel touch-key front end and LED controller, the parametrised successor of the single-channel toggle block. Each channel synchronises a raw touch-pad input, debounces it, and drives one LED under a per-channel runtime mode: toggle, momentary, long-press, or disabled. Each channel also produces one-cycle press and long-press event pulses for downstream logic. Sits between the board touch pads and the LED/application logic.

Parameters:
CH_NUM, 4, number of independent touch channels (1..16)
DEB_CNT, 50000, cycles the synchronised input must stay stable before the debounced state changes (>=1; 1 ms at 50 MHz)
LONG_CNT, 50000000, held-press cycles that qualify as a long press (>DEB_CNT; 1 s at 50 MHz)
TOUCH_ACT, 1'b0, input level meaning "touched"; the idle level is ~TOUCH_ACT
LED_INIT, 1'b1, LED reset/off level; the LED-on level is ~LED_INIT

Ports:
sys_clk  input  1  system clock, 50 MHz
sys_rst_n  input  1  asynchronous reset, active-low
touch_key  input  CH_NUM  raw asynchronous touch inputs, bit i = channel i
mode  input  2*CH_NUM  per-channel mode, bits [2i+1:2i]; 00 toggle, 01 momentary, 10 long-press, 11 disabled
led  output  CH_NUM  registered LED drive per channel
press_pulse  output  CH_NUM  registered, one-cycle pulse on each debounced press
long_pulse  output  CH_NUM  registered, one-cycle pulse when a press reaches LONG_CNT

Behaviour:
- Reset is sys_rst_n, asynchronous, active-low; the clock is sys_clk. Reset values:
  - led = {CH_NUM{LED_INIT}}
  - press_pulse = 0, long_pulse = 0
  - sync flops and debounced state = idle (~TOUCH_ACT), so no event is generated on reset release
  - all counters = 0
- Reset asserted mid-press or mid-count clears everything immediately. Release with the key held: treated as a fresh press, so a full DEB_CNT must elapse before press_pulse.
- Channels are fully independent; there is no shared state.
- Synchroniser: 2-FF per bit. A touch_key change sampled at edge 0 appears at sync output s2 at edge 1.
- Debounce:
  - Counter width is clog2(DEB_CNT)+1.
  - If s2 == deb_state, the counter resets to 0.
  - Otherwise the counter increments. On the edge where it equals DEB_CNT-1 (and s2 still differs), deb_state <= s2 and the counter <= 0.
  - Any glitch shorter than DEB_CNT cycles is discarded and the counter restarts.
  - Result: deb_state changes at edge 1+DEB_CNT after a clean input change at edge 0.
- Events:
  - press = deb_state transitions idle->active; release = active->idle.
  - press_pulse is high exactly one cycle, at edge 2+DEB_CNT. All mode-driven LED updates on press or release occur on that same edge.
- Hold counter:
  - Counts cycles while deb_state is active and saturates at LONG_CNT.
  - long_pulse fires once per press, on the edge the counter reaches LONG_CNT.
  - The counter clears on release.
  - Hold length is measured from the press edge.
- Mode 00 (toggle): led inverts on each press. Release, hold and long_pulse have no LED effect.
- Mode 01 (momentary): led = ~LED_INIT while pressed, LED_INIT otherwise, registered on the event edges.
- Mode 10 (long-press):
  - Press itself does nothing to led.
  - Release with the hold counter < LONG_CNT inverts led.
  - long_pulse forces led = LED_INIT (off).
  - Release after a long press leaves led unchanged.
- Mode 11 (disabled): led held at LED_INIT. press_pulse and long_pulse are still generated.
- Mode change:
  - mode is sampled every cycle.
  - Entering 01 or 11 forces led to that mode's rule on the next edge.
  - Entering 00 or 10 keeps the current led value.
  - A press that began under another mode is judged by the mode in force at each event edge.
- Simultaneous events: a long_pulse and a release cannot coincide, because the release clears the counter first. If a mode write coincides with an event edge, the new mode's rule applies.

Test Plan (CH_NUM=2, DEB_CNT=4, LONG_CNT=16, TOUCH_ACT=0, LED_INIT=1):
- Reset, then hold touch_key=2'b11 for 50 cycles -> led=2'b11; press_pulse and long_pulse stay 0 throughout.
- Mode 00: ch0 driven 1->0 at edge 0 and held for 10 cycles -> press_pulse[0]=1 only at edge 6 and led[0] goes 1->0 at edge 6; a second press restores led[0]=1; ch1 unaffected.
- ch0 glitch low for 3 cycles, then high -> no press_pulse and led unchanged. A subsequent 4-cycle low -> press_pulse fires.
- Mode 01 on ch1: press held 8 cycles after debounce -> led[1]=0 from the press edge, returns to 1 at edge 1+DEB_CNT+1 after the input goes high.
- Mode 10 on ch0:
  - Hold 8 cycles -> toggle on release.
  - Hold 30 cycles -> long_pulse[0] exactly once, 16 cycles after press_pulse; led[0]=1 and no toggle on release.
- Reset asserted mid-hold in mode 10, then released with the key still low -> all outputs at reset values; press_pulse at reset-release +DEB_CNT+2; mode 11 during a press -> led=1 and pulses still seen.
